// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
//   arb_state_t : arbiter FSM state encoding
//   UART_BYTE_W : width of one byte on the uart_tx byte port
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_DRAIN,
    ARB_GAP
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// Scans the request vector starting at ptr, wrapping past N-1 to 0, and returns the
// first asserted requester.
//   req   : request vector, one bit per source
//   ptr   : highest-priority index for this pick
//   found : at least one request is asserted
//   idx   : chosen source index (0 when found is low)
module rr_picker #(
  parameter int unsigned N    = 4,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic            found,
  output logic [IdxW-1:0] idx
);

  // Rotate-and-priority-encode: walk the rotated positions from last to first so the
  // lowest rotated offset (closest to ptr) is the one left standing.
  always_comb begin
    found = |req;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N]) begin
        idx = IdxW'((int'(ptr) + i) % N);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx byte port among NUM_SRC packet sources.
// A round-robin grant is held for a whole packet; after the last byte is accepted the
// arbiter waits for the uart_tx shifter to go idle, then for GAP_CYCLES clocks, before
// arbitrating again, so packets never interleave on the serial line.
//   clk, rst    : clock, asynchronous active-high reset
//   src_req     : source i has a valid byte on src_data[8i+7:8i]
//   src_data    : packed source bytes
//   src_last    : source i's byte is the last of its packet
//   src_ack     : source i's byte accepted this cycle
//   tx_data     : byte to uart_tx (0 when tx_req is low)
//   tx_req      : byte valid to uart_tx
//   tx_cts      : uart_tx can accept a byte
//   tx_idle     : uart_tx shifter empty
//   grant_valid : a source owns the port
//   grant_id    : owning source index, held outside of ownership
//   pkt_done    : pulse with the accepted last byte of a packet
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SRC-1:0]             src_req,
  input  logic [NUM_SRC*UART_BYTE_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]             src_last,
  output logic [NUM_SRC-1:0]             src_ack,
  output logic [UART_BYTE_W-1:0]         tx_data,
  output logic                           tx_req,
  input  logic                           tx_cts,
  input  logic                           tx_idle,
  output logic                           grant_valid,
  output logic [$clog2(NUM_SRC)-1:0]     grant_id,
  output logic                           pkt_done
);

  localparam int unsigned IdW     = $clog2(NUM_SRC);
  localparam int unsigned GapW    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned GapLoad = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [IdW-1:0] LastId = IdW'(NUM_SRC - 1);

  arb_state_t             state;
  logic [IdW-1:0]         rr_ptr;
  logic [GapW-1:0]        gap_cnt;
  logic                   pick_found;
  logic [IdW-1:0]         pick_idx;
  logic                   owner_req;
  logic                   owner_last;
  logic [UART_BYTE_W-1:0] owner_data;
  logic                   beat;

  rr_picker #(
    .N    (NUM_SRC),
    .IdxW (IdW)
  ) u_picker (
    .req   (src_req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign grant_valid = (state == ARB_BUSY);

  // Owner mux and handshake; combinational so the ack lands in the accept cycle.
  always_comb begin
    owner_req  = 1'b0;
    owner_last = 1'b0;
    owner_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == IdW'(i)) begin
        owner_req  = src_req[i];
        owner_last = src_last[i];
        owner_data = src_data[i*UART_BYTE_W +: UART_BYTE_W];
      end
    end
    tx_req   = grant_valid && owner_req;
    tx_data  = tx_req ? owner_data : '0;
    beat     = tx_req && tx_cts;
    pkt_done = beat && owner_last;
    src_ack  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ack[i] = beat && (grant_id == IdW'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      gap_cnt  <= '0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            state    <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          // Owner stalling (src_req low) simply holds here; there is no abort path.
          if (pkt_done) begin
            rr_ptr <= (grant_id == LastId) ? '0 : grant_id + 1'b1;
            state  <= ARB_DRAIN;
          end
        end
        ARB_DRAIN: begin
          if (tx_idle) begin
            if (GAP_CYCLES > 0) begin
              gap_cnt <= GapW'(GapLoad);
              state   <= ARB_GAP;
            end else begin
              state <= ARB_IDLE;
            end
          end
        end
        ARB_GAP: begin
          if (gap_cnt == '0) begin
            state <= ARB_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int GAP = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   src_req = '0;
  logic [N*8-1:0] src_data = '0;
  logic [N-1:0]   src_last = '0;
  logic [N-1:0]   src_ack;
  logic [7:0]     tx_data;
  logic           tx_req;
  logic           tx_cts = 1'b1;
  logic           tx_idle = 1'b1;
  logic           grant_valid;
  logic [1:0]     grant_id;
  logic           pkt_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_SRC    (N),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .src_req     (src_req),
    .src_data    (src_data),
    .src_last    (src_last),
    .src_ack     (src_ack),
    .tx_data     (tx_data),
    .tx_req      (tx_req),
    .tx_cts      (tx_cts),
    .tx_idle     (tx_idle),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .pkt_done    (pkt_done)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the port, whether we wait for the line, how many
  // blocked clocks remain, and which source has top priority next.
  int m_owner;
  int m_gid;
  bit m_drain;
  int m_gap;
  int m_next;

  // Packet sources: bytes remaining, bytes sent, base value, stall flag.
  int         left[N];
  int         idx[N];
  logic [7:0] base[N];
  bit         stall[N];
  logic [N-1:0] e_ack_q;

  // Observations taken from the DUT at the sampling point.
  logic [16:0]  cap;
  int           grant_log[$];
  int           gap_log[$];
  logic [11:0]  byte_log[$];
  bit           gv_prev;
  int           idle_run;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*8-1:0] data;
    logic [N-1:0]   last;
    logic [16:0]    exp;  // {tx_req, tx_data, src_ack, grant_valid, grant_id, pkt_done}
  } vec_t;

  vec_t tbl[16];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_gid   = 0;
    m_drain = 1'b0;
    m_gap   = 0;
    m_next  = 0;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      left[i]  = 0;
      idx[i]   = 0;
      base[i]  = 8'h00;
      stall[i] = 1'b0;
    end
    src_req  = '0;
    src_data = '0;
    src_last = '0;
  endtask

  task automatic start_pkt(input int s, input int len, input logic [7:0] b);
    left[s] = len;
    idx[s]  = 0;
    base[s] = b;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      src_req[i]        = (left[i] > 0) && !stall[i];
      src_data[8*i +: 8] = base[i] + 8'(idx[i]);
      src_last[i]       = (left[i] == 1);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (left[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_logs();
    grant_log.delete();
    gap_log.delete();
    byte_log.delete();
    gv_prev  = 1'b0;
    idle_run = 0;
  endtask

  // One clock: compare against the model at the falling edge, advance the model,
  // then move the sources on after the rising edge.
  task automatic step();
    logic         e_gv, e_req, e_done;
    logic [7:0]   e_data;
    logic [N-1:0] e_ack;
    logic [16:0]  exp;
    @(negedge clk);
    e_gv   = (m_owner >= 0);
    e_req  = 1'b0;
    e_data = 8'h00;
    e_done = 1'b0;
    e_ack  = '0;
    if (e_gv) begin
      e_req = src_req[m_owner];
      if (e_req) e_data = src_data[8*m_owner +: 8];
      if (e_req && tx_cts) begin
        e_ack[m_owner] = 1'b1;
        e_done         = src_last[m_owner];
      end
    end
    exp = {e_req, e_data, e_ack, e_gv, 2'(m_gid), e_done};
    cap = {tx_req, tx_data, src_ack, grant_valid, grant_id, pkt_done};
    n_vec++;
    if (cap !== exp) begin
      n_err++;
      $display("FAIL model t=%0t got {req,data,ack,gv,gid,done}=%h,%h,%b,%b,%0d,%b expected %h,%h,%b,%b,%0d,%b",
               $time, tx_req, tx_data, src_ack, grant_valid, grant_id, pkt_done,
               e_req, e_data, e_ack, e_gv, m_gid, e_done);
    end
    if (grant_valid && !gv_prev) begin
      grant_log.push_back(int'(grant_id));
      gap_log.push_back(idle_run);
      idle_run = 0;
    end
    if (!grant_valid) idle_run++;
    gv_prev = grant_valid;
    for (int i = 0; i < N; i++) if (src_ack[i]) byte_log.push_back({4'(i), tx_data});
    if (rst) begin
      model_reset();
    end else if (m_owner >= 0) begin
      if (e_done) begin
        m_next  = (m_owner + 1) % N;
        m_owner = -1;
        m_drain = 1'b1;
      end
    end else if (m_drain) begin
      if (tx_idle) begin
        m_drain = 1'b0;
        m_gap   = GAP;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (m_owner < 0 && src_req[(m_next + k) % N]) begin
          m_owner = (m_next + k) % N;
          m_gid   = m_owner;
        end
      end
    end
    e_ack_q = e_ack;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (e_ack_q[i] && left[i] > 0) begin
        left[i]--;
        idx[i]++;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tx_cts  = 1'b1;
    tx_idle = 1'b1;
    clear_sources();
    model_reset();
    step();
    step();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic run_until_empty(input int max, input string name);
    int c;
    for (c = 0; c < max; c++) begin
      if (all_empty()) break;
      drive();
      step();
    end
    check({name, "_done_in_budget"}, 64'(all_empty()), 64'd1);
    for (int k = 0; k < 3; k++) begin
      drive();
      step();
    end
  endtask

  initial begin
    int         c;
    int         scnt;
    bit         restarted;
    logic [3:0] pat;

    // Reset values, checked before any clock edge.
    #1 rst = 1'b1;
    #2;
    check("reset_tx_req", 64'(tx_req), 64'd0);
    check("reset_tx_data", 64'(tx_data), 64'd0);
    check("reset_src_ack", 64'(src_ack), 64'd0);
    check("reset_grant_valid", 64'(grant_valid), 64'd0);
    check("reset_grant_id", 64'(grant_id), 64'd0);
    check("reset_pkt_done", 64'(pkt_done), 64'd0);
    apply_reset();

    // Table: src1 sends "Hi\n", then re-requests during the gap.
    for (int r = 0; r < 16; r++) begin
      tbl[r].req  = 4'b0010;
      tbl[r].data = 32'h0000_5500;
      tbl[r].last = 4'b0010;
      tbl[r].exp  = {1'b0, 8'h00, 4'b0000, 1'b0, 2'd1, 1'b0};
    end
    tbl[0]  = '{4'b0010, 32'h0000_4800, 4'b0000, {1'b0, 8'h00, 4'b0000, 1'b0, 2'd0, 1'b0}};
    tbl[1]  = '{4'b0010, 32'h0000_4800, 4'b0000, {1'b1, 8'h48, 4'b0010, 1'b1, 2'd1, 1'b0}};
    tbl[2]  = '{4'b0010, 32'h0000_6900, 4'b0000, {1'b1, 8'h69, 4'b0010, 1'b1, 2'd1, 1'b0}};
    tbl[3]  = '{4'b0010, 32'h0000_0A00, 4'b0010, {1'b1, 8'h0A, 4'b0010, 1'b1, 2'd1, 1'b1}};
    tbl[4]  = '{4'b0000, 32'h0000_0000, 4'b0000, {1'b0, 8'h00, 4'b0000, 1'b0, 2'd1, 1'b0}};
    tbl[14] = '{4'b0010, 32'h0000_5500, 4'b0010, {1'b1, 8'h55, 4'b0010, 1'b1, 2'd1, 1'b1}};
    tbl[15] = '{4'b0000, 32'h0000_0000, 4'b0000, {1'b0, 8'h00, 4'b0000, 1'b0, 2'd1, 1'b0}};
    for (int r = 0; r < 16; r++) begin
      src_req  = tbl[r].req;
      src_data = tbl[r].data;
      src_last = tbl[r].last;
      step();
      check($sformatf("hi_table_row%0d", r), 64'(cap), 64'(tbl[r].exp));
    end

    // Reset in the middle of a packet, src0 presenting byte 2.
    apply_reset();
    start_pkt(0, 4, 8'h10);
    for (c = 0; c < 50 && idx[0] < 2; c++) begin
      drive();
      step();
    end
    check("rst_mid_setup_byte", 64'(idx[0]), 64'd2);
    drive();
    #1 rst = 1'b1;
    #1;
    check("rst_mid_tx_req", 64'(tx_req), 64'd0);
    check("rst_mid_src_ack", 64'(src_ack), 64'd0);
    check("rst_mid_grant_valid", 64'(grant_valid), 64'd0);
    model_reset();
    clear_sources();
    start_pkt(0, 4, 8'h10);
    drive();
    step();
    rst = 1'b0;
    clear_logs();
    run_until_empty(100, "rst_restart");
    check("rst_restart_count", 64'(byte_log.size()), 64'd4);
    check("rst_restart_first", 64'(byte_log[0]), 64'h010);

    // Contention: all four at once.
    apply_reset();
    for (int i = 0; i < N; i++) start_pkt(i, 2, 8'(16 * (i + 1)));
    run_until_empty(400, "contention");
    check("contention_grants", 64'(grant_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) check($sformatf("contention_order%0d", k), 64'(grant_log[k]), 64'(k));
    for (int k = 1; k < 4; k++)
      check($sformatf("contention_gap%0d_ge_%0d", k, GAP), 64'(gap_log[k] >= GAP), 64'd1);

    // Fairness: src0 re-requests immediately, src2 waiting.
    apply_reset();
    start_pkt(0, 2, 8'h20);
    start_pkt(2, 2, 8'h40);
    restarted = 1'b0;
    for (c = 0; c < 300; c++) begin
      if (!restarted && left[0] == 0) begin
        start_pkt(0, 2, 8'h28);
        restarted = 1'b1;
      end
      if (all_empty()) break;
      drive();
      step();
    end
    check("fair_done_in_budget", 64'(all_empty()), 64'd1);
    check("fair_grants", 64'(grant_log.size()), 64'd3);
    check("fair_order", {grant_log[0][15:0], grant_log[1][15:0], grant_log[2][15:0]}, 48'h0000_0002_0000);

    // Backpressure: cts pattern 1,0,0,1.
    apply_reset();
    start_pkt(1, 4, 8'h50);
    pat = 4'b1001;
    for (c = 0; c < 100 && !all_empty(); c++) begin
      tx_cts = pat[c % 4];
      drive();
      step();
    end
    tx_cts = 1'b1;
    check("bp_count", 64'(byte_log.size()), 64'd4);
    for (int k = 0; k < 4; k++) check($sformatf("bp_byte%0d", k), 64'(byte_log[k]), 64'({4'd1, 8'h50 + 8'(k)}));

    // Stall: owner src0 drops req for 5 clocks while src3 waits.
    apply_reset();
    start_pkt(0, 4, 8'h30);
    start_pkt(3, 2, 8'h70);
    scnt = 0;
    for (c = 0; c < 200 && !all_empty(); c++) begin
      stall[0] = (idx[0] == 1 && scnt < 5);
      if (stall[0]) scnt++;
      drive();
      step();
    end
    check("stall_done_in_budget", 64'(all_empty()), 64'd1);
    check("stall_bytes", 64'(byte_log.size()), 64'd6);
    for (int k = 0; k < 4; k++) check($sformatf("stall_owner%0d", k), 64'(byte_log[k]), 64'({4'd0, 8'h30 + 8'(k)}));
    check("stall_src3_after", 64'(byte_log[4]), 64'h370);
    check("stall_grants", {grant_log[0][15:0], grant_log[1][15:0]}, 32'h0000_0003);

    // Random traffic against the model.
    apply_reset();
    for (c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (left[i] == 0 && $urandom_range(7) == 0)
          start_pkt(i, 1 + int'($urandom_range(3)), 8'($urandom));
        stall[i] = ($urandom_range(4) == 0);
      end
      tx_cts  = ($urandom_range(2) != 0);
      tx_idle = ($urandom_range(1) != 0);
      drive();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
